// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (port 0)
// and a multicycle helper (port 1); each port owns a one-entry response buffer.
// Ports: clock/resetn; reqN_* request handshake + operands; rspN_* buffered
// response handshake (result, flags {illegal, ovf, lt, ne}); alu_* drive and
// sample the shared external ALU.
module alu_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clock,
  input  logic        resetn,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req0_shamt,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req1_shamt,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,

  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan,
  input  logic        alu_overflow
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  localparam logic       FIXED    = (FIXED_PRIO != 0);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  // rr_ptr: 1 = port 1 favoured on the next tie
  logic        rr_ptr;
  logic [7:0]  wait_cnt;

  logic        elig0;
  logic        elig1;
  logic        both;
  logic        pick1;
  logic        grant0;
  logic        grant1;

  logic        illegal;
  logic [31:0] cap_result;
  logic [3:0]  cap_flags;

  // A port may only win if its buffer is free or drains this edge.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);
  assign both  = elig0 & elig1;

  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      both &  FIXED: pick1 = (wait_cnt == WAIT_LIM);
      both & ~FIXED: pick1 = rr_ptr;
      ~both:         pick1 = elig1;
      default:       pick1 = 1'b0;
    endcase
  end

  assign grant0 = elig0 & ~pick1;
  assign grant1 = elig1 & pick1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Idle cycles park the ALU on port 0's fields.
  assign alu_operandA = grant1 ? req1_opA    : req0_opA;
  assign alu_operandB = grant1 ? req1_opB    : req0_opB;
  assign alu_opcode   = grant1 ? req1_opcode : req0_opcode;
  assign alu_shamt    = grant1 ? req1_shamt  : req0_shamt;

  always_comb begin
    illegal = 1'b1;
    unique case (alu_opcode)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLL, OP_SRA: illegal = 1'b0;
      default:               illegal = 1'b1;
    endcase
  end

  // Illegal opcodes never expose whatever the ALU computed.
  assign cap_result = illegal ? 32'd0 : alu_result;
  assign cap_flags  = illegal ? 4'b1000
                    : {1'b0, alu_overflow,
                       alu_isLessThan, alu_isNotEqual};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= 32'd0;
      rsp0_flags  <= 4'd0;
    end else if (grant0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= cap_result;
      rsp0_flags  <= cap_flags;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= 32'd0;
      rsp1_flags  <= 4'd0;
    end else if (grant1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= cap_result;
      rsp1_flags  <= cap_flags;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

  // Round-robin pointer favours the loser of the last accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= 1'b0;
    end else if (!FIXED && (grant0 || grant1)) begin
      rr_ptr <= grant0;
    end
  end

  // Starvation counter; only counts cycles port 1 could have gone.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= 8'd0;
    end else if (!FIXED || !req1_valid || grant1) begin
      wait_cnt <= 8'd0;
    end else if (elig1 && wait_cnt < WAIT_LIM) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (round-robin, and fixed priority with
// MAX_WAIT=3) driven by random and directed requests, scoreboard-checked.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        ov;
    logic        lt;
    logic        ne;
  } alu_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } req_t;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
  } rsp_t;

  logic        v    [2][2];
  logic [31:0] a    [2][2];
  logic [31:0] b    [2][2];
  logic [4:0]  op   [2][2];
  logic [4:0]  sh   [2][2];
  logic        take [2][2];
  logic        rdy  [2][2];
  logic        rv   [2][2];
  logic [31:0] res  [2][2];
  logic [3:0]  fl   [2][2];

  logic [31:0] xa  [2];
  logic [31:0] xb  [2];
  logic [31:0] xr  [2];
  logic [4:0]  xop [2];
  logic [4:0]  xsh [2];
  logic        xne [2];
  logic        xlt [2];
  logic        xov [2];

  // reference state
  rsp_t q   [4][$];
  req_t dq  [4][$];
  logic occ [2][2];
  logic acc [2][2];
  logic mrr;
  int   mwait;

  int n_chk;
  int n_fail;
  int pv;
  int rmode [2];

  function automatic alu_t alu_model(input logic [4:0] o,
                                     input logic [31:0] x,
                                     input logic [31:0] y,
                                     input logic [4:0] s);
    alu_t t;
    logic [31:0] sum;
    logic [31:0] dif;
    sum  = x + y;
    dif  = x - y;
    t.ne = (x != y);
    t.lt = ($signed(x) < $signed(y));
    t.ov = 1'b0;
    case (o)
      5'd0: begin
        t.r  = sum;
        t.ov = (x[31] == y[31]) && (sum[31] != x[31]);
      end
      5'd1: begin
        t.r  = dif;
        t.ov = (x[31] != y[31]) && (dif[31] != x[31]);
      end
      5'd2: t.r = x & y;
      5'd3: t.r = x | y;
      5'd4: t.r = x << s;
      5'd5: t.r = $signed(x) >>> s;
      default: begin
        t.r  = x ^ y ^ 32'h5a5a_a5a5;
        t.ov = 1'b1;
        t.ne = 1'b1;
      end
    endcase
    return t;
  endfunction

  function automatic rsp_t exp_of(input req_t rq);
    rsp_t e;
    alu_t t;
    t = alu_model(rq.op, rq.a, rq.b, rq.sh);
    if (rq.op <= 5'd5) begin
      e.r = t.r;
      e.f = {1'b0, t.ov, t.lt, t.ne};
    end else begin
      e.r = 32'd0;
      e.f = 4'b1000;
    end
    return e;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++)
      {xr[d], xov[d], xlt[d], xne[d]} =
        alu_model(xop[d], xa[d], xb[d], xsh[d]);
  end

  alu_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(8)) u0 (
    .clock(clk), .resetn(resetn),
    .req0_valid(v[0][0]), .req0_ready(rdy[0][0]),
    .req0_opA(a[0][0]), .req0_opB(b[0][0]),
    .req0_opcode(op[0][0]), .req0_shamt(sh[0][0]),
    .req1_valid(v[0][1]), .req1_ready(rdy[0][1]),
    .req1_opA(a[0][1]), .req1_opB(b[0][1]),
    .req1_opcode(op[0][1]), .req1_shamt(sh[0][1]),
    .rsp0_valid(rv[0][0]), .rsp0_ready(take[0][0]),
    .rsp0_result(res[0][0]), .rsp0_flags(fl[0][0]),
    .rsp1_valid(rv[0][1]), .rsp1_ready(take[0][1]),
    .rsp1_result(res[0][1]), .rsp1_flags(fl[0][1]),
    .alu_operandA(xa[0]), .alu_operandB(xb[0]),
    .alu_opcode(xop[0]), .alu_shamt(xsh[0]),
    .alu_result(xr[0]), .alu_isNotEqual(xne[0]),
    .alu_isLessThan(xlt[0]), .alu_overflow(xov[0])
  );

  alu_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(3)) u1 (
    .clock(clk), .resetn(resetn),
    .req0_valid(v[1][0]), .req0_ready(rdy[1][0]),
    .req0_opA(a[1][0]), .req0_opB(b[1][0]),
    .req0_opcode(op[1][0]), .req0_shamt(sh[1][0]),
    .req1_valid(v[1][1]), .req1_ready(rdy[1][1]),
    .req1_opA(a[1][1]), .req1_opB(b[1][1]),
    .req1_opcode(op[1][1]), .req1_shamt(sh[1][1]),
    .rsp0_valid(rv[1][0]), .rsp0_ready(take[1][0]),
    .rsp0_result(res[1][0]), .rsp0_flags(fl[1][0]),
    .rsp1_valid(rv[1][1]), .rsp1_ready(take[1][1]),
    .rsp1_result(res[1][1]), .rsp1_flags(fl[1][1]),
    .alu_operandA(xa[1]), .alu_operandB(xb[1]),
    .alu_opcode(xop[1]), .alu_shamt(xsh[1]),
    .alu_result(xr[1]), .alu_isNotEqual(xne[1]),
    .alu_isLessThan(xlt[1]), .alu_overflow(xov[1])
  );

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    int k;
    if (resetn) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          k = d * 2 + p;
          check($sformatf("rsp_valid d%0d p%0d", d, p),
                rv[d][p], q[k].size() != 0);
          if (rv[d][p] && q[k].size() != 0) begin
            check($sformatf("rsp d%0d p%0d", d, p),
                  {res[d][p], fl[d][p]}, {q[k][0].r, q[k][0].f});
            if (take[d][p]) void'(q[k].pop_front());
          end
        end
      end
    end
  end

  // Issue side: predicts the grant and queues the expected response.
  always @(negedge clk) begin
    logic e0, e1, g0, g1, g;
    int   k;
    req_t rq;
    #1;
    if (resetn) begin
      for (int d = 0; d < 2; d++) begin
        e0 = v[d][0] && (!occ[d][0] || take[d][0]);
        e1 = v[d][1] && (!occ[d][1] || take[d][1]);
        if (e0 && e1) begin
          g1 = (d == 1) ? (mwait == 3) : mrr;
          g0 = !g1;
        end else begin
          g0 = e0;
          g1 = e1;
        end
        check($sformatf("req_ready d%0d", d),
              {rdy[d][0], rdy[d][1]}, {g0, g1});
        check($sformatf("alu_fields d%0d", d),
              {xop[d], xa[d], xb[d], xsh[d]},
              g1 ? {op[d][1], a[d][1], b[d][1], sh[d][1]}
                 : {op[d][0], a[d][0], b[d][0], sh[d][0]});
        for (int p = 0; p < 2; p++) begin
          k = d * 2 + p;
          g = (p == 1) ? g1 : g0;
          if (g) begin
            rq = '{op: op[d][p], a: a[d][p], b: b[d][p], sh: sh[d][p]};
            q[k].push_back(exp_of(rq));
            occ[d][p] = 1'b1;
          end else if (take[d][p]) begin
            occ[d][p] = 1'b0;
          end
          acc[d][p] = g;
        end
        if (d == 0) begin
          if (g0 || g1) mrr = g0;
        end else begin
          if (!v[1][1] || g1) mwait = 0;
          else if (e1 && mwait < 3) mwait++;
        end
      end
    end
  end

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7fff_ffff;
      3: return 32'h8000_0000;
      4: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    int r;
    r = $urandom_range(0, 8);
    if (r <= 5) return 5'(r);
    if (r == 6) return 5'd7;
    return 5'($urandom_range(6, 31));
  endfunction

  task automatic push_dir(input int p, input logic [4:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s);
    for (int d = 0; d < 2; d++)
      dq[d * 2 + p].push_back('{op: o, a: x, b: y, sh: s});
  endtask

  task automatic drive();
    int   k;
    req_t t;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        k = d * 2 + p;
        if (!(v[d][p] && !acc[d][p])) begin
          if (dq[k].size() > 0) begin
            t = dq[k].pop_front();
            v[d][p] = 1'b1;
          end else begin
            t = '{op: rand_op(), a: rand_opnd(), b: rand_opnd(),
                  sh: 5'($urandom_range(0, 31))};
            v[d][p] = ($urandom_range(0, 99) < pv);
          end
          op[d][p] = t.op;
          a[d][p]  = t.a;
          b[d][p]  = t.b;
          sh[d][p] = t.sh;
        end
        case (rmode[p])
          1:       take[d][p] = 1'b1;
          2:       take[d][p] = 1'b0;
          default: take[d][p] = ($urandom_range(0, 99) < 70);
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        v[d][p]   = 1'b0;
        acc[d][p] = 1'b0;
        occ[d][p] = 1'b0;
        q[d * 2 + p].delete();
      end
    end
    mrr   = 1'b0;
    mwait = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    pv     = 0;
    rmode[0] = 1;
    rmode[1] = 1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        v[d][p]    = 1'b0;
        a[d][p]    = 32'd0;
        b[d][p]    = 32'd0;
        op[d][p]   = 5'd0;
        sh[d][p]   = 5'd0;
        take[d][p] = 1'b0;
      end
    end
    apply_reset();

    // accept 5+7 then reset before it drains
    rmode[0] = 2;
    rmode[1] = 2;
    push_dir(0, 5'd0, 32'd5, 32'd7, 5'd0);
    step();
    step();
    check("pre-reset rsp0_valid", rv[0][0], 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("reset rsp0_valid u0", rv[0][0], 1'b0);
    check("reset rsp0_valid u1", rv[1][0], 1'b0);
    check("reset rsp0_result", {res[0][0], fl[0][0]}, 36'd0);
    check("reset rr_ptr", u0.rr_ptr, 1'b0);
    check("reset wait_cnt", u1.wait_cnt, 8'd0);
    apply_reset();
    rmode[0] = 1;
    rmode[1] = 1;
    push_dir(0, 5'd0, 32'd5, 32'd7, 5'd0);

    // directed ALU cases
    push_dir(0, 5'd1, 32'd3, 32'd5, 5'd0);
    push_dir(0, 5'd0, 32'h7fff_ffff, 32'd1, 5'd0);
    push_dir(1, 5'd7, 32'd1, 32'd1, 5'd0);
    push_dir(1, 5'd4, 32'd1, 32'd0, 5'd31);
    push_dir(1, 5'd5, 32'h8000_0000, 32'd0, 5'd4);
    repeat (10) step();

    // both ports saturated: alternation vs starvation limit
    apply_reset();
    pv = 100;
    for (int k = 0; k < 12; k++) begin
      step();
      #6;
      check($sformatf("rr grant c%0d", k),
            {rdy[0][0], rdy[0][1]}, {k % 2 == 0, k % 2 == 1});
      check($sformatf("starve grant c%0d", k),
            {rdy[1][0], rdy[1][1]}, {k % 4 != 3, k % 4 == 3});
    end

    // port 1 backpressure must not stall port 0
    apply_reset();
    rmode[1] = 2;
    for (int k = 0; k < 10; k++) begin
      step();
      #6;
      if (k >= 2)
        check($sformatf("bp u0 c%0d", k),
              {rdy[0][0], rdy[0][1]}, 2'b10);
      if (k >= 4)
        check($sformatf("bp u1 c%0d", k),
              {rdy[1][0], rdy[1][1]}, 2'b10);
    end
    rmode[1] = 1;
    step();
    #6;
    check("drain+fill grant u0", rdy[0][1], 1'b1);
    step();
    check("drain+fill rsp1_valid", rv[0][1], 1'b1);

    // random traffic
    pv = 70;
    rmode[0] = 0;
    rmode[1] = 0;
    repeat (3000) step();

    pv = 0;
    rmode[0] = 1;
    rmode[1] = 1;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
